// File: rtl/ip_top_chk_smurf_mrnw_if.sv
// ip_top_chk_smurf_mrnw_if: logical and physical memory port bundle
// observed by the single-bit shadow checker. The environment drives
// it (master); the checker only watches it (slave).
interface ip_top_chk_smurf_mrnw_if #(
   parameter int WIDTH    = 16,
   parameter int BITADDR  = 10,
   parameter int NUMRDPRT = 2,
   parameter int NUMWRPRT = 3,
   parameter int NUMPHYRD = 2,
   parameter int NUMPHYWR = 3
);
   // logical side
   logic [NUMRDPRT-1:0]         read;
   logic [NUMRDPRT*BITADDR-1:0] rd_adr;
   logic [NUMRDPRT-1:0]         rd_vld;
   logic [NUMRDPRT*WIDTH-1:0]   rd_dout;
   logic [NUMWRPRT-1:0]         write;
   logic [NUMWRPRT*BITADDR-1:0] wr_adr;
   logic [NUMWRPRT*WIDTH-1:0]   din;
   logic [NUMWRPRT*WIDTH-1:0]   bw;
   // physical side
   logic [NUMPHYWR-1:0]         t1_write;
   logic [NUMPHYWR*BITADDR-1:0] t1_waddr;
   logic [NUMPHYWR*WIDTH-1:0]   t1_din;
   logic [NUMPHYWR*WIDTH-1:0]   t1_bw;
   logic [NUMPHYRD-1:0]         t1_read;
   logic [NUMPHYRD*BITADDR-1:0] t1_raddr;
   logic [NUMPHYRD*WIDTH-1:0]   t1_dout;

   modport master (
      output read, rd_adr, rd_vld, rd_dout, write, wr_adr, din, bw,
      output t1_write, t1_waddr, t1_din, t1_bw, t1_read, t1_raddr, t1_dout
   );

   modport slave (
      input read, rd_adr, rd_vld, rd_dout, write, wr_adr, din, bw,
      input t1_write, t1_waddr, t1_din, t1_bw, t1_read, t1_raddr, t1_dout
   );
endinterface

// File: rtl/ip_top_chk_smurf_mrnw.sv
// ip_top_chk_smurf_mrnw: tracks one (select_addr, select_bit) location of a
// multi-port memory through both its logical and physical port views and
// flags read mismatches, logical/physical shadow incoherence, and keeps a
// sticky error state, first-error class and saturating error count.
// Optional feature: define SMURF_CHK_SVA_EN to add concurrent assertions
// (no errors) and address-range assumptions on every active strobe.
module ip_top_chk_smurf_mrnw #(
   parameter int WIDTH      = 16,
   parameter int BITWDTH    = 4,
   parameter int NUMADDR    = 1024,
   parameter int BITADDR    = 10,
   parameter int NUMRDPRT   = 2,
   parameter int NUMWRPRT   = 3,
   parameter int NUMPHYRD   = 2,
   parameter int NUMPHYWR   = 3,
   parameter int SRAM_DELAY = 1,
   parameter int FLOPIN     = 0,
   parameter int FLOPOUT    = 0,
   parameter int ERRCNTW    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   ip_top_chk_smurf_mrnw_if.slave    bus,
   input  logic [BITADDR-1:0]        select_addr,
   input  logic [BITWDTH-1:0]        select_bit,
   input  logic                      err_clr,
   output logic [NUMPHYRD-1:0]       err_phy,
   output logic [NUMRDPRT-1:0]       err_log,
   output logic                      err_coh,
   output logic                      err_sticky,
   output logic [ERRCNTW-1:0]        err_cnt,
   output logic [1:0]                err_first
);

   localparam int LOGDLY = FLOPIN + SRAM_DELAY + FLOPOUT;

   if (NUMADDR > (1 << BITADDR)) begin : g_bad_numaddr
      $error("NUMADDR does not fit in BITADDR address bits");
   end

   typedef enum logic {ARMED, FAILED} state_t;

   state_t state, state_nxt;

   logic pinv, pbit, linv, lbit;

   // ---------------------------------------------------------------
   // Write-side match detection, one bit per port
   // ---------------------------------------------------------------
   logic [NUMPHYWR-1:0] pw_match, pw_bit;
   logic [NUMWRPRT-1:0] lw_match, lw_bit;
   logic                pw_upd, pw_val, lw_upd, lw_val;

   for (genvar g = 0; g < NUMPHYWR; g++) begin : g_pwr
      logic [WIDTH-1:0] din_w, bw_w;
      assign din_w       = bus.t1_din[g*WIDTH +: WIDTH];
      assign bw_w        = bus.t1_bw[g*WIDTH +: WIDTH];
      assign pw_bit[g]   = din_w[select_bit];
      assign pw_match[g] = bus.t1_write[g] && bw_w[select_bit] &&
                           (bus.t1_waddr[g*BITADDR +: BITADDR] == select_addr);
   end

   for (genvar g = 0; g < NUMWRPRT; g++) begin : g_lwr
      logic [WIDTH-1:0] din_w, bw_w;
      assign din_w       = bus.din[g*WIDTH +: WIDTH];
      assign bw_w        = bus.bw[g*WIDTH +: WIDTH];
      assign lw_bit[g]   = din_w[select_bit];
      assign lw_match[g] = bus.write[g] && bw_w[select_bit] &&
                           (bus.wr_adr[g*BITADDR +: BITADDR] == select_addr);
   end

   // Pick the highest-numbered matching write port on each side.
   always_comb begin
      pw_upd = 1'b0;
      pw_val = 1'b0;
      lw_upd = 1'b0;
      lw_val = 1'b0;
      for (int unsigned i = 0; i < NUMPHYWR; i++) begin
         if (pw_match[i]) begin
            pw_upd = 1'b1;
            pw_val = pw_bit[i];
         end
      end
      for (int unsigned i = 0; i < NUMWRPRT; i++) begin
         if (lw_match[i]) begin
            lw_upd = 1'b1;
            lw_val = lw_bit[i];
         end
      end
   end

   // Shadow copies of the tracked bit as seen by the physical and logical views.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pinv <= 1'b1;
         pbit <= 1'b0;
         linv <= 1'b1;
         lbit <= 1'b0;
      end else begin
         if (pw_upd) begin
            pinv <= 1'b0;
            pbit <= pw_val;
         end
         if (lw_upd) begin
            linv <= 1'b0;
            lbit <= lw_val;
         end
      end
   end

   // ---------------------------------------------------------------
   // Physical read checking
   // ---------------------------------------------------------------
   for (genvar g = 0; g < NUMPHYRD; g++) begin : g_phy
      logic [WIDTH-1:0] dout_w;
      logic             hit_now;
      assign dout_w  = bus.t1_dout[g*WIDTH +: WIDTH];
      assign hit_now = bus.t1_read[g] &&
                       (bus.t1_raddr[g*BITADDR +: BITADDR] == select_addr);
      if (SRAM_DELAY == 0) begin : g_comb
         assign err_phy[g] = hit_now && !pinv && (dout_w[select_bit] != pbit);
      end else begin : g_pipe
         // stage 0 of each *_s vector is the live hit-cycle value
         logic [SRAM_DELAY-1:0] hit_q, inv_q, bit_q;
         logic [SRAM_DELAY:0]   hit_s, inv_s, bit_s;
         assign hit_s = {hit_q, hit_now};
         assign inv_s = {inv_q, pinv};
         assign bit_s = {bit_q, pbit};
         // Carry each hit and its captured shadow until the read data returns.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hit_q <= '0;
               inv_q <= '0;
               bit_q <= '0;
            end else begin
               hit_q <= hit_s[SRAM_DELAY-1:0];
               inv_q <= inv_s[SRAM_DELAY-1:0];
               bit_q <= bit_s[SRAM_DELAY-1:0];
            end
         end
         assign err_phy[g] = hit_q[SRAM_DELAY-1] && !inv_q[SRAM_DELAY-1] &&
                             (dout_w[select_bit] != bit_q[SRAM_DELAY-1]);
      end
   end

   // ---------------------------------------------------------------
   // Logical read checking
   // ---------------------------------------------------------------
   for (genvar g = 0; g < NUMRDPRT; g++) begin : g_log
      logic [WIDTH-1:0] dout_w;
      logic             hit_now;
      assign dout_w  = bus.rd_dout[g*WIDTH +: WIDTH];
      assign hit_now = bus.read[g] &&
                       (bus.rd_adr[g*BITADDR +: BITADDR] == select_addr);
      if (LOGDLY == 0) begin : g_comb
         assign err_log[g] = hit_now && !linv &&
                             (!bus.rd_vld[g] || (dout_w[select_bit] != lbit));
      end else begin : g_pipe
         logic [LOGDLY-1:0] hit_q, inv_q, bit_q;
         logic [LOGDLY:0]   hit_s, inv_s, bit_s;
         assign hit_s = {hit_q, hit_now};
         assign inv_s = {inv_q, linv};
         assign bit_s = {bit_q, lbit};
         // Carry each hit and its captured shadow through the full logical latency.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hit_q <= '0;
               inv_q <= '0;
               bit_q <= '0;
            end else begin
               hit_q <= hit_s[LOGDLY-1:0];
               inv_q <= inv_s[LOGDLY-1:0];
               bit_q <= bit_s[LOGDLY-1:0];
            end
         end
         assign err_log[g] = hit_q[LOGDLY-1] && !inv_q[LOGDLY-1] &&
                             (!bus.rd_vld[g] || (dout_w[select_bit] != bit_q[LOGDLY-1]));
      end
   end

   assign err_coh = !linv && (pinv || (pbit != lbit));

   // ---------------------------------------------------------------
   // Error state machine and counter
   // ---------------------------------------------------------------
   logic       any_err;
   logic [1:0] err_cls, first_nxt;
   logic [ERRCNTW-1:0] cnt_nxt;

   assign any_err = (|err_phy) || (|err_log) || err_coh;

   // Next state, first-error class and count; a clear coinciding with a new error restarts from that error.
   always_comb begin
      state_nxt = state;
      first_nxt = err_first;
      cnt_nxt   = err_cnt;
      err_cls   = 2'd0;
      if (|err_phy)      err_cls = 2'd1;
      else if (|err_log) err_cls = 2'd2;
      else if (err_coh)  err_cls = 2'd3;
      case (state)
         ARMED: begin
            if (any_err) begin
               state_nxt = FAILED;
               first_nxt = err_cls;
            end
         end
         FAILED: begin
            if (err_clr) begin
               if (any_err) begin
                  first_nxt = err_cls;
               end else begin
                  state_nxt = ARMED;
                  first_nxt = 2'd0;
               end
            end
         end
         default: begin
            state_nxt = ARMED;
            first_nxt = 2'd0;
         end
      endcase
      if (err_clr)
         cnt_nxt = ERRCNTW'(any_err);
      else if (any_err && (err_cnt != '1))
         cnt_nxt = err_cnt + 1'b1;
   end

   // Error state, first-error class and saturating count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ARMED;
         err_first <= 2'd0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         err_first <= first_nxt;
         err_cnt   <= cnt_nxt;
      end
   end

   assign err_sticky = (state == FAILED);

`ifdef SMURF_CHK_SVA_EN
   localparam logic [BITADDR:0] ADDR_LIM = (BITADDR+1)'(NUMADDR);

   a_no_err_phy: assert property (@(posedge clk) disable iff (rst) err_phy == '0);
   a_no_err_log: assert property (@(posedge clk) disable iff (rst) err_log == '0);
   a_no_err_coh: assert property (@(posedge clk) disable iff (rst) err_coh == 1'b0);

   for (genvar g = 0; g < NUMPHYRD; g++) begin : g_asm_prd
      m_rng: assume property (@(posedge clk) disable iff (rst)
         bus.t1_read[g] |-> ({1'b0, bus.t1_raddr[g*BITADDR +: BITADDR]} < ADDR_LIM));
   end
   for (genvar g = 0; g < NUMPHYWR; g++) begin : g_asm_pwr
      m_rng: assume property (@(posedge clk) disable iff (rst)
         bus.t1_write[g] |-> ({1'b0, bus.t1_waddr[g*BITADDR +: BITADDR]} < ADDR_LIM));
   end
   for (genvar g = 0; g < NUMRDPRT; g++) begin : g_asm_lrd
      m_rng: assume property (@(posedge clk) disable iff (rst)
         bus.read[g] |-> ({1'b0, bus.rd_adr[g*BITADDR +: BITADDR]} < ADDR_LIM));
   end
   for (genvar g = 0; g < NUMWRPRT; g++) begin : g_asm_lwr
      m_rng: assume property (@(posedge clk) disable iff (rst)
         bus.write[g] |-> ({1'b0, bus.wr_adr[g*BITADDR +: BITADDR]} < ADDR_LIM));
   end
`endif

endmodule
